// File: rtl/sad_csa_accumulator.sv
// Sum of absolute differences over BLK_LEN beats of LANES pixel pairs.
// A carry-save accumulator keeps the per-beat path free of carry chains; one final add resolves it.
module sad_csa_accumulator #(
  parameter int LANES   = 7,
  parameter int PIX_W   = 8,
  parameter int BLK_LEN = 16,
  localparam int SAD_W  = PIX_W + $clog2(LANES * BLK_LEN + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*PIX_W-1:0]   pix_a,
  input  logic [LANES*PIX_W-1:0]   pix_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SAD_W-1:0]         sad
);

  localparam int CNT_W = (BLK_LEN > 1) ? $clog2(BLK_LEN) : 1;

  typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, RESOLVE, HOLD} state_t;

  state_t                 state, state_nx;
  logic [CNT_W-1:0]       cnt;
  logic                   accept;
  logic                   last_beat;
  logic                   s1_valid;
  logic [PIX_W-1:0]       diff [LANES];
  logic [PIX_W-1:0]       d1   [LANES];
  logic [SAD_W-1:0]       acc_s, acc_c;
  logic [SAD_W-1:0]       cs_s, cs_c, csa_op, csa_cy;

  assign in_ready  = (state == IDLE) || (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign last_beat = (cnt == CNT_W'(BLK_LEN - 1));

  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      diff[i] = (pix_a[i*PIX_W +: PIX_W] > pix_b[i*PIX_W +: PIX_W])
              ? pix_a[i*PIX_W +: PIX_W] - pix_b[i*PIX_W +: PIX_W]
              : pix_b[i*PIX_W +: PIX_W] - pix_a[i*PIX_W +: PIX_W];
    end
  end

  // S1 data needs no reset: s1_valid gates every use of it.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned i = 0; i < LANES; i++) d1[i] <= diff[i];
    end
  end

  // Chain of 3:2 compressors folding each lane into the redundant pair.
  // Carries shifted past SAD_W are dropped; the true total always fits, so the modulo sum stays exact.
  always_comb begin
    cs_s   = acc_s;
    cs_c   = acc_c;
    csa_op = '0;
    csa_cy = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      csa_op = SAD_W'(d1[i]);
      csa_cy = ((cs_s & cs_c) | (cs_s & csa_op) | (cs_c & csa_op)) << 1;
      cs_s   = cs_s ^ cs_c ^ csa_op;
      cs_c   = csa_cy;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      s1_valid <= 1'b0;
    end else if (clr) begin
      cnt      <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) cnt <= last_beat ? '0 : cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_s <= '0;
      acc_c <= '0;
    end else if (clr || (state == HOLD && out_ready)) begin
      acc_s <= '0;
      acc_c <= '0;
    end else if (s1_valid) begin
      acc_s <= cs_s;
      acc_c <= cs_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sad <= '0;
    end else if (!clr && state == RESOLVE) begin
      sad <= acc_s + acc_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   state <= IDLE;
    else if (clr) state <= IDLE;
    else          state <= state_nx;
  end

  // DRAIN waits one edge past the last S2 update so sad lands three edges after the last accept.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = last_beat ? DRAIN : ACCUM;
      ACCUM:   if (accept && last_beat) state_nx = DRAIN;
      DRAIN:   if (!s1_valid) state_nx = RESOLVE;
      RESOLVE: state_nx = HOLD;
      HOLD:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

endmodule
